// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths, write-request type and arbiter state encoding
//               for the register-file write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wdata;
    } wr_req_t;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_wr_fifo.sv
// ============================================================================
// Module      : regfile_wr_fifo
// Description : Synchronous FIFO of write requests with flush on reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wr_fifo
    import regfile_pkg::*;
#(
    parameter type ENTRY_T = wr_req_t,
    parameter int  DEPTH   = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  logic   pop_i,
    input  ENTRY_T data_i,
    output ENTRY_T head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int c_ptr_w = $clog2(DEPTH);

    ENTRY_T             mem_q [DEPTH];
    logic [c_ptr_w:0]   wr_ptr_q;
    logic [c_ptr_w:0]   rd_ptr_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[c_ptr_w] != rd_ptr_q[c_ptr_w]) &&
                     (wr_ptr_q[c_ptr_w-1:0] == rd_ptr_q[c_ptr_w-1:0]);
    assign head_o  = mem_q[rd_ptr_q[c_ptr_w-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + (c_ptr_w+1)'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + (c_ptr_w+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[c_ptr_w-1:0]] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Shares the register-file write port between core writeback
//               and a buffered aux source; optionally scrubs x1..x31 first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int AUX_DEPTH      = 2,
    parameter int MAX_WAIT       = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_we_i,
    input  logic [REG_ADDR_W-1:0] core_rd_i,
    input  logic [XLEN-1:0]       core_wdata_i,
    output logic                  core_stall_o,
    input  logic                  aux_valid_i,
    output logic                  aux_ready_o,
    input  logic [REG_ADDR_W-1:0] aux_rd_i,
    input  logic [XLEN-1:0]       aux_wdata_i,
    output logic                  rf_we_o,
    output logic [REG_ADDR_W-1:0] rf_rsw_o,
    output logic [XLEN-1:0]       rf_dataW_o,
    output logic                  init_done_o
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wdata;
    } aux_req_t;

    localparam int                    c_starve_w   = $clog2(MAX_WAIT+1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(MAX_WAIT);
    localparam logic [REG_ADDR_W-1:0] c_last_idx   = REG_ADDR_W'(NUM_REGS-1);

    arb_state_e            state_q, state_d;
    logic [REG_ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [c_starve_w-1:0] starve_q, starve_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_rsw_q, rf_rsw_d;
    logic [XLEN-1:0]       rf_dataW_q, rf_dataW_d;

    logic                  grant_vld;
    logic [REG_ADDR_W-1:0] grant_rd;
    logic [XLEN-1:0]       grant_data;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    aux_req_t              fifo_in;
    aux_req_t              fifo_head;

    assign fifo_in = '{rd: aux_rd_i, wdata: aux_wdata_i};
    assign push    = aux_valid_i & aux_ready_o;

    regfile_wr_fifo #(
        .ENTRY_T (aux_req_t),
        .DEPTH   (AUX_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (fifo_in),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        starve_d     = starve_q;
        grant_vld    = 1'b0;
        grant_rd     = '0;
        grant_data   = '0;
        pop          = 1'b0;
        core_stall_o = 1'b0;
        aux_ready_o  = 1'b0;
        case (state_q)
            CLEAR: begin
                core_stall_o = 1'b1;
                grant_vld    = 1'b1;
                grant_rd     = clr_idx_q;
                clr_idx_d    = clr_idx_q + REG_ADDR_W'(1);
                if (clr_idx_q == c_last_idx) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Ready ignores a same-cycle pop so a full buffer never pushes through.
                aux_ready_o = ~fifo_full;
                if (!fifo_empty && (starve_q == c_starve_max)) begin
                    grant_vld    = 1'b1;
                    grant_rd     = fifo_head.rd;
                    grant_data   = fifo_head.wdata;
                    pop          = 1'b1;
                    starve_d     = '0;
                    core_stall_o = core_we_i;
                end else if (core_we_i) begin
                    grant_vld  = 1'b1;
                    grant_rd   = core_rd_i;
                    grant_data = core_wdata_i;
                    if (fifo_empty) begin
                        starve_d = '0;
                    end else if (starve_q != c_starve_max) begin
                        starve_d = starve_q + c_starve_w'(1);
                    end
                end else if (!fifo_empty) begin
                    grant_vld  = 1'b1;
                    grant_rd   = fifo_head.rd;
                    grant_data = fifo_head.wdata;
                    pop        = 1'b1;
                    starve_d   = '0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // x0 writes are still consumed by the grant but never reach the register file.
    assign rf_we_d    = grant_vld && (grant_rd != '0);
    assign rf_rsw_d   = grant_rd;
    assign rf_dataW_d = grant_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_idx_q  <= REG_ADDR_W'(1);
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_rsw_q   <= '0;
            rf_dataW_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_rsw_q   <= rf_rsw_d;
            rf_dataW_q <= rf_dataW_d;
        end
    end

    assign rf_we_o     = rf_we_q;
    assign rf_rsw_o    = rf_rsw_q;
    assign rf_dataW_o  = rf_dataW_q;
    assign init_done_o = (state_q == RUN);

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Directed self-checking bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wr_arbiter;

    localparam int XLEN      = 32;
    localparam int AUX_DEPTH = 2;
    localparam int MAX_WAIT  = 4;

    logic            clk;
    logic            rst;
    logic            core_we;
    logic [4:0]      core_rd;
    logic [XLEN-1:0] core_wdata;
    logic            core_stall;
    logic            aux_valid;
    logic            aux_ready;
    logic [4:0]      aux_rd;
    logic [XLEN-1:0] aux_wdata;
    logic            rf_we;
    logic [4:0]      rf_rsw;
    logic [XLEN-1:0] rf_dataW;
    logic            init_done;

    logic            nc_zero;
    logic [4:0]      nc_rd_zero;
    logic [XLEN-1:0] nc_data_zero;
    logic            nc_core_stall;
    logic            nc_aux_ready;
    logic            nc_rf_we;
    logic [4:0]      nc_rf_rsw;
    logic [XLEN-1:0] nc_rf_dataW;
    logic            nc_init_done;

    regfile_wr_arbiter #(
        .XLEN(XLEN), .AUX_DEPTH(AUX_DEPTH), .MAX_WAIT(MAX_WAIT), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .core_we_i(core_we), .core_rd_i(core_rd), .core_wdata_i(core_wdata),
        .core_stall_o(core_stall),
        .aux_valid_i(aux_valid), .aux_ready_o(aux_ready),
        .aux_rd_i(aux_rd), .aux_wdata_i(aux_wdata),
        .rf_we_o(rf_we), .rf_rsw_o(rf_rsw), .rf_dataW_o(rf_dataW),
        .init_done_o(init_done)
    );

    regfile_wr_arbiter #(
        .XLEN(XLEN), .AUX_DEPTH(AUX_DEPTH), .MAX_WAIT(MAX_WAIT), .CLEAR_ON_RESET(0)
    ) dut_nc (
        .clk(clk), .rst(rst),
        .core_we_i(nc_zero), .core_rd_i(nc_rd_zero), .core_wdata_i(nc_data_zero),
        .core_stall_o(nc_core_stall),
        .aux_valid_i(nc_zero), .aux_ready_o(nc_aux_ready),
        .aux_rd_i(nc_rd_zero), .aux_wdata_i(nc_data_zero),
        .rf_we_o(nc_rf_we), .rf_rsw_o(nc_rf_rsw), .rf_dataW_o(nc_rf_dataW),
        .init_done_o(nc_init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue for the aux buffer, a scrub counter and a
    // starvation count, advanced once per cycle from the current inputs.
    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] d;
    } ent_t;

    ent_t            m_q[$];
    bit              m_valid = 0;
    bit              m_run;
    int              m_clr;
    int              m_starve;
    bit              e_we;
    logic [4:0]      e_rsw;
    logic [XLEN-1:0] e_data;
    bit              g_vld;
    logic [4:0]      g_rd;
    logic [XLEN-1:0] g_d;
    bit              e_stall;
    bit              e_ready;
    bit              m_push;
    ent_t            m_head;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_rf_we", rf_we, e_we);
            if (e_we) begin
                chk("model_rf_rsw", rf_rsw, e_rsw);
                chk("model_rf_dataW", rf_dataW, e_data);
            end
            chk("model_init_done", init_done, m_run);
        end
        if (rst) begin
            m_valid  = 1;
            m_run    = 0;
            m_clr    = 0;
            m_starve = 0;
            m_q.delete();
            e_we     = 0;
            e_rsw    = '0;
            e_data   = '0;
        end else if (m_valid) begin
            g_vld = 0; g_rd = '0; g_d = '0;
            if (!m_run) begin
                e_stall = 1; e_ready = 0;
                g_vld = 1; g_rd = 5'(m_clr + 1); g_d = '0;
                m_clr++;
                if (m_clr == 31) m_run = 1;
                m_push = 0;
            end else begin
                e_ready = (m_q.size() < AUX_DEPTH);
                e_stall = 0;
                m_push  = aux_valid && e_ready;
                if (m_q.size() > 0 && m_starve == MAX_WAIT) begin
                    m_head = m_q.pop_front();
                    g_vld = 1; g_rd = m_head.rd; g_d = m_head.d;
                    m_starve = 0;
                    e_stall = core_we;
                end else if (core_we) begin
                    g_vld = 1; g_rd = core_rd; g_d = core_wdata;
                    m_starve = (m_q.size() > 0) ? ((m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT) : 0;
                end else if (m_q.size() > 0) begin
                    m_head = m_q.pop_front();
                    g_vld = 1; g_rd = m_head.rd; g_d = m_head.d;
                    m_starve = 0;
                end
                if (m_push) m_q.push_back('{rd: aux_rd, d: aux_wdata});
            end
            chk("model_core_stall", core_stall, e_stall);
            chk("model_aux_ready", aux_ready, e_ready);
            e_we   = g_vld && (g_rd != 0);
            e_rsw  = g_rd;
            e_data = g_d;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scrub_check();
        for (int i = 1; i <= 31; i++) begin
            chk("scrub_stall", core_stall, 1);
            chk("scrub_aux_ready", aux_ready, 0);
            step();
            chk("scrub_we", rf_we, 1);
            chk("scrub_rsw", rf_rsw, 32'(i));
            chk("scrub_data", rf_dataW, 0);
            chk("scrub_init_done", init_done, (i == 31) ? 1 : 0);
        end
    endtask

    logic [4:0] seq[$];
    bit         acc;
    int         stalls;
    int         stall_at;

    initial begin
        rst = 1; core_we = 0; core_rd = '0; core_wdata = '0;
        aux_valid = 0; aux_rd = '0; aux_wdata = '0;
        nc_zero = 0; nc_rd_zero = '0; nc_data_zero = '0;
        step(); step();
        rst = 0;

        // Scrub after reset; the non-clearing instance is already running.
        chk("init_done_after_reset", init_done, 0);
        chk("nc_init_done_first", nc_init_done, 1);
        scrub_check();
        step();
        chk("post_scrub_idle_we", rf_we, 0);
        chk("nc_no_writes", nc_rf_we, 0);

        // Single core write.
        core_we = 1; core_rd = 5'd3; core_wdata = 32'd9966;
        #1 chk("core_stall_core_only", core_stall, 0);
        step();
        chk("core_we", rf_we, 1);
        chk("core_rsw", rf_rsw, 3);
        chk("core_data", rf_dataW, 32'd9966);

        // Three aux pushes against a busy core; the third must wait.
        core_rd = 5'd20; core_wdata = 32'h1234;
        aux_valid = 1; aux_rd = 5'd5; aux_wdata = 32'h55;
        #1 chk("aux_ready_1", aux_ready, 1);
        step();
        aux_rd = 5'd6; aux_wdata = 32'h66;
        #1 chk("aux_ready_2", aux_ready, 1);
        step();
        aux_rd = 5'd7; aux_wdata = 32'h77;
        #1 chk("aux_ready_full", aux_ready, 0);
        step();
        core_we = 0;
        seq.delete();
        for (int k = 0; k < 6; k++) begin
            #1 acc = aux_valid && aux_ready;
            step();
            if (acc) aux_valid = 0;
            if (rf_we) seq.push_back(rf_rsw);
        end
        chk("aux_order_count", 32'(seq.size()), 3);
        if (seq.size() == 3) begin
            chk("aux_order_0", seq[0], 5);
            chk("aux_order_1", seq[1], 6);
            chk("aux_order_2", seq[2], 7);
        end
        aux_valid = 0;

        // Starvation: one aux entry behind a continuously writing core.
        core_we = 1; core_rd = 5'd9; core_wdata = 32'd100;
        aux_valid = 1; aux_rd = 5'd8; aux_wdata = 32'd88;
        seq.delete(); stalls = 0; stall_at = -1;
        for (int k = 0; k < 8; k++) begin
            #1 if (core_stall) begin stalls++; stall_at = k; end
            step();
            if (k == 0) aux_valid = 0;
            if (rf_we) seq.push_back(rf_rsw);
        end
        chk("starve_stall_count", 32'(stalls), 1);
        chk("starve_stall_cycle", 32'(stall_at), 5);
        chk("starve_seq_len", 32'(seq.size()), 8);
        if (seq.size() == 8) begin
            chk("starve_before", seq[4], 9);
            chk("starve_aux", seq[5], 8);
            chk("starve_after", seq[6], 9);
        end
        core_we = 0;
        step();

        // Writes to x0 are consumed silently.
        core_we = 1; core_rd = 5'd0; core_wdata = 32'hFFFF_FFFF;
        #1 chk("x0_core_stall", core_stall, 0);
        step();
        chk("x0_core_we", rf_we, 0);
        core_we = 0;
        aux_valid = 1; aux_rd = 5'd0; aux_wdata = 32'hABC;
        #1 chk("x0_aux_ready", aux_ready, 1);
        step();
        aux_valid = 0;
        step();
        chk("x0_aux_we", rf_we, 0);
        #1 chk("x0_aux_popped", aux_ready, 1);
        step();
        chk("x0_idle_we", rf_we, 0);

        // Reset mid-run with two aux entries queued behind the core.
        core_we = 1; core_rd = 5'd1; core_wdata = 32'd1;
        aux_valid = 1; aux_rd = 5'd10; aux_wdata = 32'd10;
        step();
        aux_rd = 5'd11; aux_wdata = 32'd11;
        step();
        aux_valid = 0; core_we = 0;
        rst = 1;
        step();
        rst = 0;
        chk("reset_rf_we", rf_we, 0);
        chk("reset_init_done", init_done, 0);
        scrub_check();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("reset_no_stale_aux", rf_we, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
